// File: rtl/reg_2bytes_uart_rx_if.sv
// ----------------------------------------------------------------------------
// reg_2bytes_uart_rx_if
//   Bundles the byte stream coming from uart_rx with the 2-byte command word
//   and status pulses going to the command decoder.
//
//   Signals:
//     rx_done   1  1-cycle pulse: rx_data holds a new byte
//     rx_data   8  received byte, valid only while rx_done=1
//     byte_one  8  first byte of the last completed pair
//     byte_two  8  second byte of the last completed pair
//     done      1  1-cycle pulse: byte_one/byte_two updated this cycle
//     busy      1  high while waiting for the second byte
//     timeout   1  1-cycle pulse: orphan first byte discarded
//
//   Modports:
//     master  byte source side (drives rx_done/rx_data, observes results)
//     slave   the pair assembler (reg_2bytes_uart_rx)
// ----------------------------------------------------------------------------
interface reg_2bytes_uart_rx_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [7:0] byte_one;
    logic [7:0] byte_two;
    logic       done;
    logic       busy;
    logic       timeout;

    modport master (
        output rx_done, rx_data,
        input  byte_one, byte_two, done, busy, timeout
    );

    modport slave (
        input  rx_done, rx_data,
        output byte_one, byte_two, done, busy, timeout
    );
endinterface

// File: rtl/reg_2bytes_uart_rx.sv
// ----------------------------------------------------------------------------
// reg_2bytes_uart_rx
//   Receive-side companion of the two-byte UART transmit sequencer. Collects
//   two consecutive bytes from uart_rx and presents them as one 2-byte command
//   word, pulsing done when the pair is complete.
//
//   Optional feature macro: REG2B_RX_TIMEOUT_EN
//     defined     - an inter-byte timer discards an orphan first byte after
//                   TIMEOUT_CYCLES cycles and pulses timeout, so the link
//                   resynchronises.
//     not defined - no timer; the second byte is awaited indefinitely and
//                   timeout is tied low.
//
//   Parameters (only with REG2B_RX_TIMEOUT_EN):
//     TIMEOUT_CYCLES  max cycles between byte 1 and byte 2
//     TIMEOUT_W       timer width, 2**TIMEOUT_W > TIMEOUT_CYCLES
//
//   Ports:
//     clk    system clock, all logic on posedge
//     reset  asynchronous reset, active-high
//     bus    reg_2bytes_uart_rx_if.slave (rx_done/rx_data in; byte_one,
//            byte_two, done, busy, timeout out)
// ----------------------------------------------------------------------------
module reg_2bytes_uart_rx
`ifdef REG2B_RX_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int TIMEOUT_W      = 23
)
`endif
(
    input logic                 clk,
    input logic                 reset,
    reg_2bytes_uart_rx_if.slave bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_TWO = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] byte_one_q, byte_one_d;
    logic [7:0] byte_two_q, byte_two_d;
    logic       done_q, done_d;

`ifdef REG2B_RX_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic                 timeout_q, timeout_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d    = state_q;
        hold_d     = hold_q;
        byte_one_d = byte_one_q;
        byte_two_d = byte_two_q;
        done_d     = 1'b0;
`ifdef REG2B_RX_TIMEOUT_EN
        timer_d    = timer_q;
        timeout_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.rx_done) begin
                    hold_d  = bus.rx_data;
                    state_d = WAIT_TWO;
`ifdef REG2B_RX_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end

            WAIT_TWO: begin
                // A second byte beats timer expiry when both land together.
                if (bus.rx_done) begin
                    byte_one_d = hold_q;
                    byte_two_d = bus.rx_data;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
`ifdef REG2B_RX_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    // Timer stops at its last value; leaving WAIT_TWO means
                    // it never wraps.
                    timeout_d = 1'b1;
                    hold_d    = '0;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            byte_one_q <= '0;
            byte_two_q <= '0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q    <= state_d;
            hold_q     <= hold_d;
            byte_one_q <= byte_one_d;
            byte_two_q <= byte_two_d;
            done_q     <= done_d;
        end
    end

`ifdef REG2B_RX_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.byte_one = byte_one_q;
    assign bus.byte_two = byte_two_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q == WAIT_TWO);

endmodule
